// File: rtl/mult_issue_ctrl.sv
// Issue controller for the 16x16 signed parity-protected multiplier.
// Optional: `define PARITY_INJECT_EN adds inj_a_perr/inj_b_perr parity-inversion inputs.
module mult_issue_ctrl #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [15:0] arg_a,
  output logic        arg_a_parity,
  output logic [15:0] arg_b,
  output logic        arg_b_parity,
  output logic        req,
  input  logic        ack,
  input  logic [31:0] result,
  input  logic        result_parity,
  input  logic        result_rdy,
  input  logic        arg_parity_error,
`ifdef PARITY_INJECT_EN
  input  logic        inj_a_perr,
  input  logic        inj_b_perr,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_arg_perr,
  output logic        out_res_perr,
  output logic        out_timeout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [15:0]   mem_a_q [DEPTH];
  logic [15:0]   mem_b_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          full, push, pop;

  logic [1:0]    state_q, state_d;
  logic          req_q, req_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   arg_a_q, arg_a_d;
  logic [15:0]   arg_b_q, arg_b_d;
  logic          par_a_q, par_a_d;
  logic          par_b_q, par_b_d;
  logic          ov_q, ov_d;
  logic [31:0]   res_q, res_d;
  logic          aperr_q, aperr_d;
  logic          rperr_q, rperr_d;
  logic          to_q, to_d;
  logic          inj_a, inj_b;
  logic          tmo_last;

`ifdef PARITY_INJECT_EN
  assign inj_a = inj_a_perr;
  assign inj_b = inj_b_perr;
`else
  assign inj_a = 1'b0;
  assign inj_b = 1'b0;
`endif

  // in_ready depends only on registered occupancy
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign push     = in_valid && !full;
  assign pop      = (state_q == S_IDLE) && (cnt_q != '0);
  assign tmo_last = (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wptr_q] <= in_a;
      mem_b_q[wptr_q] <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    tmo_d   = tmo_q;
    arg_a_d = arg_a_q;
    arg_b_d = arg_b_q;
    par_a_d = par_a_q;
    par_b_d = par_b_q;
    ov_d    = ov_q;
    res_d   = res_q;
    aperr_d = aperr_q;
    rperr_d = rperr_q;
    to_d    = to_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          arg_a_d = mem_a_q[rptr_q];
          arg_b_d = mem_b_q[rptr_q];
          par_a_d = ^mem_a_q[rptr_q] ^ inj_a;
          par_b_d = ^mem_b_q[rptr_q] ^ inj_b;
          req_d   = 1'b1;
          tmo_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        if (state_q == S_REQ && ack) begin
          req_d = 1'b0;
          tmo_d = '0;
          state_d = S_WAIT;
        end
        // result capture wins over both ack-only and timeout
        if ((state_q == S_REQ && ack && result_rdy) ||
            (state_q == S_WAIT && result_rdy)) begin
          res_d   = result;
          aperr_d = arg_parity_error;
          rperr_d = ^result ^ result_parity;
          to_d    = 1'b0;
          ov_d    = 1'b1;
          state_d = S_OUT;
        end else if (!(state_q == S_REQ && ack)) begin
          if (tmo_last) begin
            req_d   = 1'b0;
            res_d   = '0;
            aperr_d = 1'b0;
            rperr_d = 1'b0;
            to_d    = 1'b1;
            ov_d    = 1'b1;
            state_d = S_OUT;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          res_d   = '0;
          aperr_d = 1'b0;
          rperr_d = 1'b0;
          to_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      tmo_q   <= '0;
      arg_a_q <= '0;
      arg_b_q <= '0;
      par_a_q <= 1'b0;
      par_b_q <= 1'b0;
      ov_q    <= 1'b0;
      res_q   <= '0;
      aperr_q <= 1'b0;
      rperr_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      tmo_q   <= tmo_d;
      arg_a_q <= arg_a_d;
      arg_b_q <= arg_b_d;
      par_a_q <= par_a_d;
      par_b_q <= par_b_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      aperr_q <= aperr_d;
      rperr_q <= rperr_d;
      to_q    <= to_d;
    end
  end

  assign in_ready     = !full;
  assign arg_a        = arg_a_q;
  assign arg_b        = arg_b_q;
  assign arg_a_parity = par_a_q;
  assign arg_b_parity = par_b_q;
  assign req          = req_q;
  assign out_valid    = ov_q;
  assign out_result   = res_q;
  assign out_arg_perr = aperr_q;
  assign out_res_perr = rperr_q;
  assign out_timeout  = to_q;

endmodule
